icache_assoc: RTL and testbench

- Parametrised N-way set-associative, read-only instruction cache between the CPU fetch stage and the instruction memory.
- Successor to the direct-mapped 8-line icache: block size, set count, associativity and address width are configurable.
- Adds per-set round-robin replacement with invalid-way preference, whole-cache INVALIDATE, and saturating hit/miss counters.
- Fully synchronous: all state updates happen on the rising edge of CLK.

---
 rtl/icache_pkg.sv | 33 +++
 rtl/icache_way_select.sv | 20 ++
 rtl/icache_assoc.sv | 166 ++++++++++++++++
 tb/tb_icache_assoc.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  function automatic int unsigned off_w(input int unsigned block_words);
    return $clog2(block_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                        input int unsigned block_words);
    return addr_w - idx_w(sets) - off_w(block_words);
  endfunction

  // A direct-mapped cache still carries a 1-bit way/pointer field that is always 0.
  function automatic int unsigned ptr_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Extract an address field; fields are narrower than 32 bits.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int unsigned lsb,
                                             input int unsigned width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_way_select.sv
// Victim choice for one set: lowest invalid way first, else the round-robin pointer.
module icache_way_select
  import icache_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] victim
);

  always_comb begin
    victim = ptr;
    for (int unsigned i = WAYS; i > 0; i--) begin
      if (!valid[i-1]) victim = PTR_W'(i - 1);
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache with round-robin refill,
// global invalidate and saturating hit/miss counters.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [ADDR_W-1:0]             ADDRESS,
  output logic [WORD_W-1:0]             INSTRUCTION,
  output logic                          BUSYWAIT,
  input  logic                          INVALIDATE,
  output logic                          MEM_READ,
  output logic [ADDR_W-off_w(BLOCK_WORDS)-1:0] MEM_ADDRESS,
  input  logic                          MEM_BUSYWAIT,
  input  logic [WORD_W*BLOCK_WORDS-1:0] MEM_INSTRUCTION,
  output logic [CNT_W-1:0]              HIT_COUNT,
  output logic [CNT_W-1:0]              MISS_COUNT
);

  localparam int unsigned OFF_W = off_w(BLOCK_WORDS);
  localparam int unsigned IDX_W = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(ADDR_W, SETS, BLOCK_WORDS);
  localparam int unsigned PTR_W = ptr_w(WAYS);
  localparam int unsigned BLK_W = WORD_W * BLOCK_WORDS;

  logic [31:0]      addr_ext;
  logic [OFF_W-1:0] cur_off;
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;

  assign addr_ext = 32'(ADDRESS);
  assign cur_off  = OFF_W'(addr_field(addr_ext, 0, OFF_W));
  assign cur_idx  = IDX_W'(addr_field(addr_ext, OFF_W, IDX_W));
  assign cur_tag  = TAG_W'(addr_field(addr_ext, OFF_W + IDX_W, TAG_W));

  logic [WAYS-1:0]  valid_q [SETS];
  logic [PTR_W-1:0] ptr_q   [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [BLK_W-1:0] data_q  [SETS][WAYS];

  state_t state_q, state_d;
  logic [TAG_W+IDX_W-1:0] lat_blk_q;
  logic [PTR_W-1:0]       lat_way_q;
  logic [IDX_W-1:0]       lat_idx;
  logic [TAG_W-1:0]       lat_tag;
  logic [CNT_W-1:0]       hit_cnt_q, miss_cnt_q;
  logic [WAYS-1:0]        hit_vec;
  logic                   hit;
  logic [WORD_W-1:0]      hit_word;
  logic [PTR_W-1:0]       victim;
  logic                   hit_take, miss_detect, fill;

  assign lat_idx = lat_blk_q[IDX_W-1:0];
  assign lat_tag = lat_blk_q[IDX_W +: TAG_W];

  always_comb begin
    hit_vec  = '0;
    hit_word = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[cur_idx][w] && (tag_q[cur_idx][w] == cur_tag)) begin
        hit_vec[w] = 1'b1;
        hit_word   = data_q[cur_idx][w][32'(cur_off)*WORD_W +: WORD_W];
      end
    end
    hit = |hit_vec;
  end

  assign INSTRUCTION = hit_word;
  assign HIT_COUNT   = hit_cnt_q;
  assign MISS_COUNT  = miss_cnt_q;

  icache_way_select #(
    .WAYS (WAYS),
    .PTR_W(PTR_W)
  ) u_way_select (
    .valid (valid_q[cur_idx]),
    .ptr   (ptr_q[cur_idx]),
    .victim(victim)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Outputs are gated by RESET so a reset mid-fetch drops MEM_READ immediately.
  always_comb begin
    state_d     = state_q;
    BUSYWAIT    = 1'b1;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    hit_take    = 1'b0;
    miss_detect = 1'b0;
    fill        = 1'b0;
    if (!RESET) begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            BUSYWAIT = 1'b0;
            hit_take = 1'b1;
          end else begin
            miss_detect = 1'b1;
            state_d     = FETCH;
          end
        end
        FETCH: begin
          MEM_READ    = 1'b1;
          MEM_ADDRESS = lat_blk_q;
          if (!MEM_BUSYWAIT) begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Fill follows invalidate so a fill on the same edge leaves its line valid.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      lat_blk_q  <= '0;
      lat_way_q  <= '0;
    end else begin
      if (INVALIDATE) begin
        for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
      end
      if (hit_take && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (miss_detect) begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        lat_blk_q <= {cur_tag, cur_idx};
        lat_way_q <= victim;
      end
      if (fill) begin
        valid_q[lat_idx][lat_way_q] <= 1'b1;
        if (lat_way_q == ptr_q[lat_idx])
          ptr_q[lat_idx] <= (lat_way_q == PTR_W'(WAYS - 1)) ? '0 : lat_way_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      data_q[lat_idx][lat_way_q] <= MEM_INSTRUCTION;
      tag_q[lat_idx][lat_way_q]  <= lat_tag;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) multi_hit : assert ($onehot0(hit_vec));
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: default 2-way, 4-way/8-word/4-bit counters, and direct-mapped.
module tb_icache_assoc;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  // A: defaults (2-way), B: ADDR_W=10, 4-way, 8-word blocks, CNT_W=4, C: direct-mapped
  logic [7:0]   a_addr;  logic [31:0] a_instr; logic a_busy, a_inv, a_mread, a_mbusy;
  logic [5:0]   a_maddr; logic [127:0] a_mdata; logic [15:0] a_hits, a_miss;
  logic [9:0]   b_addr;  logic [31:0] b_instr; logic b_busy, b_inv, b_mread, b_mbusy;
  logic [6:0]   b_maddr; logic [255:0] b_mdata; logic [3:0] b_hits, b_miss;
  logic [7:0]   c_addr;  logic [31:0] c_instr; logic c_busy, c_inv, c_mread, c_mbusy;
  logic [5:0]   c_maddr; logic [127:0] c_mdata; logic [15:0] c_hits, c_miss;

  int cmp = 0;
  int err = 0;

  icache_assoc dut_a (
    .CLK(clk), .RESET(rst), .ADDRESS(a_addr), .INSTRUCTION(a_instr), .BUSYWAIT(a_busy),
    .INVALIDATE(a_inv), .MEM_READ(a_mread), .MEM_ADDRESS(a_maddr), .MEM_BUSYWAIT(a_mbusy),
    .MEM_INSTRUCTION(a_mdata), .HIT_COUNT(a_hits), .MISS_COUNT(a_miss));

  icache_assoc #(.ADDR_W(10), .BLOCK_WORDS(8), .WAYS(4), .CNT_W(4)) dut_b (
    .CLK(clk), .RESET(rst), .ADDRESS(b_addr), .INSTRUCTION(b_instr), .BUSYWAIT(b_busy),
    .INVALIDATE(b_inv), .MEM_READ(b_mread), .MEM_ADDRESS(b_maddr), .MEM_BUSYWAIT(b_mbusy),
    .MEM_INSTRUCTION(b_mdata), .HIT_COUNT(b_hits), .MISS_COUNT(b_miss));

  icache_assoc #(.WAYS(1)) dut_c (
    .CLK(clk), .RESET(rst), .ADDRESS(c_addr), .INSTRUCTION(c_instr), .BUSYWAIT(c_busy),
    .INVALIDATE(c_inv), .MEM_READ(c_mread), .MEM_ADDRESS(c_maddr), .MEM_BUSYWAIT(c_mbusy),
    .MEM_INSTRUCTION(c_mdata), .HIT_COUNT(c_hits), .MISS_COUNT(c_miss));

  // Memory word contents: block address in bits [11:4], word index in [3:0].
  function automatic logic [31:0] dword(input int blk, input int w);
    return 32'hC0DE_0000 | 32'(blk << 4) | 32'(w);
  endfunction

  // Memory responders: stay busy for LAT cycles of MEM_READ, then present the block.
  initial begin : mem_a
    int cnt;
    cnt = 0; a_mbusy = 1'b1; a_mdata = '0;
    forever begin
      @(negedge clk);
      if (a_mread) begin
        cnt++;
        if (cnt > 5) begin
          a_mbusy = 1'b0;
          for (int w = 0; w < 4; w++) a_mdata[w*32 +: 32] = dword(int'(a_maddr), w);
        end
      end else begin
        cnt = 0; a_mbusy = 1'b1;
      end
    end
  end

  initial begin : mem_b
    int cnt;
    cnt = 0; b_mbusy = 1'b1; b_mdata = '0;
    forever begin
      @(negedge clk);
      if (b_mread) begin
        cnt++;
        if (cnt > 2) begin
          b_mbusy = 1'b0;
          for (int w = 0; w < 8; w++) b_mdata[w*32 +: 32] = dword(int'(b_maddr), w);
        end
      end else begin
        cnt = 0; b_mbusy = 1'b1;
      end
    end
  end

  initial begin : mem_c
    int cnt;
    cnt = 0; c_mbusy = 1'b1; c_mdata = '0;
    forever begin
      @(negedge clk);
      if (c_mread) begin
        cnt++;
        if (cnt > 1) begin
          c_mbusy = 1'b0;
          for (int w = 0; w < 4; w++) c_mdata[w*32 +: 32] = dword(int'(c_maddr), w);
        end
      end else begin
        cnt = 0; c_mbusy = 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic busy_of(input int d);
    case (d)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  task automatic wait_ready(input int d, input string nm);
    int n;
    n = 0;
    while (busy_of(d) && n < 200) begin
      step();
      n++;
    end
    cmp++;
    if (busy_of(d)) begin
      err++;
      $display("FAIL %s: BUSYWAIT still 1 after %0d cycles, required 0", nm, n);
    end
  endtask

  task automatic fill(input int d, input int addr, input string nm);
    case (d)
      0:       a_addr = 8'(addr);
      1:       b_addr = 10'(addr);
      default: c_addr = 8'(addr);
    endcase
    #1;
    wait_ready(d, nm);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic        busy;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs [10];
  int   n;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; a_addr = '0; b_addr = '0; c_addr = '0;
    a_inv = 1'b0; b_inv = 1'b0; c_inv = 1'b0;
    step();
    step();
    #1;
    check("rst_busy", a_busy, 1);
    check("rst_mread", a_mread, 0);
    check("rst_maddr", a_maddr, 0);
    check("rst_hits", a_hits, 0);
    check("rst_miss", a_miss, 0);

    // 1: first miss, 5-cycle memory, fill, hits on words 0 and 3
    rst = 1'b0; a_addr = 8'h00; #1;
    check("t1_miss_busy", a_busy, 1);
    step();
    check("t1_miss_cnt", a_miss, 1);
    check("t1_mread", a_mread, 1);
    check("t1_maddr", a_maddr, 6'h00);
    repeat (5) step();
    check("t1_still_fetch", a_mread, 1);
    step();
    check("t1_fill_busy", a_busy, 0);
    check("t1_d0", a_instr, 32'hC0DE0000);
    step();
    a_addr = 8'h03; #1;
    check("t1_d3", a_instr, 32'hC0DE0003);
    step();
    check("t1_hits", a_hits, 2);

    // 2: round-robin eviction in set 0
    do_reset();
    fill(0, 'h00, "t2_f00");
    fill(0, 'h20, "t2_f20");
    fill(0, 'h40, "t2_f40");
    a_addr = 8'h20; #1;
    check("t2_20_hit", a_busy, 0);
    check("t2_20_data", a_instr, 32'hC0DE0080);
    a_addr = 8'h00; #1;
    check("t2_00_evicted", a_busy, 1);
    step();
    check("t2_00_maddr", a_maddr, 6'h00);
    check("t2_00_mread", a_mread, 1);
    wait_ready(0, "t2_refill00");
    check("t2_00_data", a_instr, 32'hC0DE0000);
    a_addr = 8'h40; #1;
    check("t2_40_kept", a_busy, 0);
    check("t2_40_data", a_instr, 32'hC0DE0100);
    a_addr = 8'h20; #1;
    check("t2_20_evicted", a_busy, 1);
    fill(0, 'h20, "t2_refill20");
    a_addr = 8'h00; #1;
    check("t2_00_kept", a_busy, 0);
    a_addr = 8'h40; #1;
    check("t2_40_ptr_way0", a_busy, 1);

    // 3: reset in the third FETCH cycle
    do_reset();
    a_addr = 8'h00; #1;
    step();
    step();
    step();
    rst = 1'b1; #1;
    check("t3_mread_drop", a_mread, 0);
    step();
    rst = 1'b0; #1;
    check("t3_hits0", a_hits, 0);
    check("t3_miss0", a_miss, 0);
    check("t3_idle_mread", a_mread, 0);
    check("t3_remiss_busy", a_busy, 1);
    step();
    check("t3_miss1", a_miss, 1);
    check("t3_mread1", a_mread, 1);
    wait_ready(0, "t3_refill");
    check("t3_data", a_instr, 32'hC0DE0000);

    // 4: invalidate alone, with a hit, and on a fill edge
    do_reset();
    fill(0, 'h08, "t4_f08");
    check("t4_08_data", a_instr, 32'hC0DE0020);
    a_inv = 1'b1; #1;
    check("t4_hit_during_inv", a_busy, 0);
    step();
    a_inv = 1'b0; #1;
    check("t4_hit_counted", a_hits, 1);
    check("t4_08_inval", a_busy, 1);
    wait_ready(0, "t4_refill08");
    a_addr = 8'h10; #1;
    step();
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      #1;
      if (!a_mbusy) break;
      n++;
    end
    a_inv = 1'b1;
    @(posedge clk);
    #1;
    a_inv = 1'b0; #1;
    check("t4_10_fill_wins", a_busy, 0);
    check("t4_10_data", a_instr, 32'hC0DE0040);
    a_addr = 8'h08; #1;
    check("t4_08_cleared", a_busy, 1);

    // 5: address change during FETCH
    do_reset();
    a_addr = 8'h04; #1;
    step();
    check("t5_maddr", a_maddr, 6'h01);
    a_addr = 8'h2C; #1;
    repeat (3) step();
    check("t5_maddr_held", a_maddr, 6'h01);
    n = 0;
    while (a_mread && n < 50) begin
      step();
      n++;
    end
    check("t5_fetch_done", a_mread, 0);
    check("t5_2c_miss", a_busy, 1);
    step();
    check("t5_2c_maddr", a_maddr, 6'h0B);
    wait_ready(0, "t5_fill2c");
    check("t5_2c_data", a_instr, 32'hC0DE00B0);
    a_addr = 8'h04; #1;
    check("t5_04_hit", a_busy, 0);
    check("t5_04_data", a_instr, 32'hC0DE0010);

    // Table-driven lookups over a mixed resident set
    vecs[0] = '{8'h00, 1'b0, 32'hC0DE0000};
    vecs[1] = '{8'h21, 1'b0, 32'hC0DE0081};
    vecs[2] = '{8'h16, 1'b0, 32'hC0DE0052};
    vecs[3] = '{8'hFF, 1'b0, 32'hC0DE03F3};
    vecs[4] = '{8'hFC, 1'b0, 32'hC0DE03F0};
    vecs[5] = '{8'h40, 1'b1, 32'h00000000};
    vecs[6] = '{8'h04, 1'b1, 32'h00000000};
    vecs[7] = '{8'hDC, 1'b1, 32'h00000000};
    vecs[8] = '{8'h23, 1'b0, 32'hC0DE0083};
    vecs[9] = '{8'h17, 1'b0, 32'hC0DE0053};
    do_reset();
    fill(0, 'h00, "tv_f00");
    fill(0, 'h20, "tv_f20");
    fill(0, 'h14, "tv_f14");
    fill(0, 'hFC, "tv_ffc");
    for (int i = 0; i < 10; i++) begin
      a_addr = vecs[i].addr; #1;
      check($sformatf("tv%0d_busy", i), a_busy, vecs[i].busy);
      check($sformatf("tv%0d_instr", i), a_instr, vecs[i].instr);
    end

    // 6a: 4-way, 8-word blocks, 4-bit counters
    do_reset();
    fill(1, 'h000, "b_f000");
    check("b_000_d0", b_instr, 32'hC0DE0000);
    b_addr = 10'h007; #1;
    check("b_007_d7", b_instr, 32'hC0DE0007);
    fill(1, 'h040, "b_f040");
    fill(1, 'h080, "b_f080");
    fill(1, 'h0C0, "b_f0c0");
    fill(1, 'h100, "b_f100");
    check("b_100_data", b_instr, 32'hC0DE0200);
    b_addr = 10'h000; #1;
    check("b_000_evicted", b_busy, 1);
    b_addr = 10'h0C5; #1;
    check("b_0c5_hit", b_busy, 0);
    check("b_0c5_data", b_instr, 32'hC0DE0185);
    fill(1, 'h000, "b_refill000");
    b_addr = 10'h040; #1;
    check("b_040_evicted", b_busy, 1);
    b_addr = 10'h080; #1;
    check("b_080_kept", b_busy, 0);
    check("b_miss6", b_miss, 6);
    repeat (20) step();
    check("b_hits_sat", b_hits, 4'hF);

    // 6b: direct-mapped
    do_reset();
    fill(2, 'h00, "c_f00");
    check("c_00_data", c_instr, 32'hC0DE0000);
    fill(2, 'h20, "c_f20");
    c_addr = 8'h00; #1;
    check("c_00_evicted", c_busy, 1);
    c_addr = 8'h22; #1;
    check("c_22_hit", c_busy, 0);
    check("c_22_data", c_instr, 32'hC0DE0082);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
